dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width of the data memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports cpu_valid / dbg_valid, input, 1 each, request present from the core LSU (port 0) or the debug loader (port 1).
REQ-005 SHALL have ports cpu_ready / dbg_ready, output, 1 each, request accepted this cycle.
REQ-006 SHALL have per-port request inputs *_addr [ADDR_W-1:0], *_we [1], *_wdata [31:0], *_size [1:0] (00 byte, 01 half, 10 word), *_sign [1].
REQ-007 SHALL have per-port responses *_resp_valid, output, 1; *_resp_rdata, output, 32; *_resp_error, output, 1.
REQ-008 SHALL have memory-side outputs mem_byte_address [ADDR_W-1:0], mem_write_enable [1], mem_write_data [32], mem_size [2], mem_sign [1], and input mem_read_data [32] (combinational read).

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-010 In IDLE, with at least one valid: SHALL grant one port, assert only its ready for one cycle, register its request, go to ACCESS.
REQ-011 If only one port is valid, that port SHALL be granted.
REQ-012 If both are valid, SHALL grant the port not granted most recently (round-robin pointer), with port 0 winning the first conflict after reset.
REQ-013 The round-robin pointer SHALL update only on a grant.
REQ-014 In ACCESS: SHALL drive the registered address, size, sign and wdata to the memory, drive mem_write_enable = registered we AND NOT error, capture mem_read_data into the response register, then go to RESP.
REQ-015 In RESP: SHALL pulse the granted port's resp_valid for exactly one cycle, then go to IDLE.
REQ-016 Latency SHALL be: accept at cycle T, memory access at T+1, resp_valid at T+2; throughput one access per 3 cycles.
REQ-017 Outside ACCESS, mem_write_enable SHALL be 0 and the other memory outputs SHALL hold their last values.
REQ-018 Both ready outputs SHALL be 0 in ACCESS and RESP; a requester SHALL hold valid and payload stable until ready.
REQ-019 SHALL flag error on size 11.
REQ-020 SHALL flag error on an access crossing the top of memory: addr + bytes(size) > 2^ADDR_W (e.g. word at 0x3FD..0x3FF, half at 0x3FF).
REQ-021 On error: mem_write_enable SHALL stay 0, resp_rdata SHALL be 0, resp_error SHALL be 1 with resp_valid; latency unchanged.
REQ-022 Misaligned non-crossing accesses SHALL be passed through unchanged; resp_rdata SHALL equal mem_read_data for reads and 0 for writes.
REQ-023 resp_error and resp_rdata SHALL be valid only while resp_valid is high and otherwise 0.

Reset
REQ-024 Reset SHALL force state IDLE, pointer to port 0, all ready/resp_valid/resp_error/mem_write_enable to 0, and resp_rdata and memory outputs to 0.
REQ-025 Reset asserted during ACCESS SHALL suppress that cycle's write and drop the in-flight response.

Structure
REQ-026 Package dmem_pkg SHALL hold the mem_size enum (BYTE, HALF, WORD), the FSM state enum, and DMEM_ADDR_W = 10.
REQ-027 The two-way round-robin grant logic SHALL be a sub-module named dmem_rr_arb2.

Verification
REQ-028 Single cpu write: word 0xDEADBEEF @0x010, then cpu read @0x010 -> write_enable high exactly one cycle at T+1; read resp_valid at T+2 with rdata 0xDEADBEEF.
REQ-029 Simultaneous cpu and dbg requests held for 3 rounds after reset -> grants cpu, dbg, cpu; each resp goes to the correct port only.
REQ-030 dbg word write @0x3FE, and cpu size=11 @0x000 -> resp_error=1, rdata 0, no write_enable pulse, memory unchanged.
REQ-031 Half 0xA5F0 written @0x005, then signed half read @0x005 -> rdata 0xFFFFA5F0; unsigned read -> 0x0000A5F0.
REQ-032 Reset asserted in the ACCESS cycle of a write of 0x12345678 @0x020 -> no write_enable, no resp_valid; following read @0x020 returns the prior value.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
// Access sizes, FSM states and the default address width.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_e;

    // Byte count of an access; the illegal encoding yields 0.
    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        logic [2:0] n;
        n = 3'd0;
        case (s)
            BYTE:    n = 3'd1;
            HALF:    n = 3'd2;
            WORD:    n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: one requester's request/response bundle toward the arbiter.
// master = requester (LSU or debug loader), slave = arbiter.
interface dmem_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
    logic [1:0]        size;
    logic              sign;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;

    modport master (
        output valid, addr, we, wdata, size, sign,
        input  ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  valid, addr, we, wdata, size, sign,
        output ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/dmem_rr_arb2.sv
// dmem_rr_arb2: two-way round-robin grant.
// Pointer favours the port not granted most recently; port 0 after reset.
module dmem_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt,
    output logic       gnt_idx
);
    logic prio_q;
    logic both;
    logic only1;

    assign both  = req[0] & req[1];
    assign only1 = req[1] & ~req[0];

    always_comb begin
        gnt_idx = 1'b0;
        unique case (1'b1)
            both:    gnt_idx = prio_q;
            only1:   gnt_idx = 1'b1;
            default: gnt_idx = 1'b0;
        endcase
    end

    assign gnt = req & (gnt_idx ? 2'b10 : 2'b01);

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (grant_en) begin
            prio_q <= ~gnt_idx;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port front end for the data memory.
// One access in flight: accept, access memory, respond.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    dmem_if.slave             cpu,
    dmem_if.slave             dbg,
    output logic [ADDR_W-1:0] mem_byte_address,
    output logic              mem_write_enable,
    output logic [31:0]       mem_write_data,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    input  logic [31:0]       mem_read_data
);
    localparam logic [ADDR_W+1:0] MEM_BYTES = (ADDR_W + 2)'(1) << ADDR_W;

    dmem_state_e state_q;
    dmem_state_e state_d;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        gnt_idx;
    logic        grant;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_size;
    logic              sel_sign;
    logic [ADDR_W+1:0] end_addr;
    logic              err_d;

    logic              we_q;
    logic              err_q;
    logic              port_q;
    logic [31:0]       rdata_q;
    logic              in_resp;

    assign req   = {dbg.valid, cpu.valid};
    assign grant = (state_q == IDLE) & (|req) & ~reset;

    dmem_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant_en (grant),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    assign sel_addr  = gnt_idx ? dbg.addr  : cpu.addr;
    assign sel_we    = gnt_idx ? dbg.we    : cpu.we;
    assign sel_wdata = gnt_idx ? dbg.wdata : cpu.wdata;
    assign sel_size  = gnt_idx ? dbg.size  : cpu.size;
    assign sel_sign  = gnt_idx ? dbg.sign  : cpu.sign;

    // Widened sum so an access ending exactly at the top is legal.
    assign end_addr = {2'b00, sel_addr}
                    + (ADDR_W + 2)'(size_bytes(sel_size));
    assign err_d    = (sel_size == 2'b11) | (end_addr > MEM_BYTES);

    always_comb begin
        state_d   = state_q;
        cpu.ready = 1'b0;
        dbg.ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d   = ACCESS;
                    cpu.ready = gnt[0];
                    dbg.ready = gnt[1];
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_byte_address <= '0;
            mem_write_data   <= '0;
            mem_size         <= '0;
            mem_sign         <= 1'b0;
            we_q             <= 1'b0;
            err_q            <= 1'b0;
            port_q           <= 1'b0;
            rdata_q          <= '0;
        end else begin
            if (grant) begin
                mem_byte_address <= sel_addr;
                mem_write_data   <= sel_wdata;
                mem_size         <= sel_size;
                mem_sign         <= sel_sign;
                we_q             <= sel_we;
                err_q            <= err_d;
                port_q           <= gnt_idx;
            end
            if (state_q == ACCESS) begin
                rdata_q <= (we_q | err_q) ? '0 : mem_read_data;
            end
        end
    end

    // Reset gates the strobe so a reset landing in ACCESS drops the write.
    assign mem_write_enable = (state_q == ACCESS) & we_q & ~err_q & ~reset;

    assign in_resp        = (state_q == RESP);
    assign cpu.resp_valid = in_resp & ~port_q;
    assign dbg.resp_valid = in_resp & port_q;
    assign cpu.resp_error = cpu.resp_valid & err_q;
    assign dbg.resp_error = dbg.resp_valid & err_q;
    assign cpu.resp_rdata = cpu.resp_valid ? rdata_q : '0;
    assign dbg.resp_rdata = dbg.resp_valid ? rdata_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter.
// A byte-array memory sits behind the DUT; a separate byte model predicts results.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fill = 1'b0;
    logic [9:0]  mem_byte_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_read_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram     [1024];
    logic [7:0] ref_mem [1024];

    dmem_if #(.ADDR_W(10)) cpu_if ();
    dmem_if #(.ADDR_W(10)) dbg_if ();

    dmem_arbiter #(.ADDR_W(10)) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu              (cpu_if),
        .dbg              (dbg_if),
        .mem_byte_address (mem_byte_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_size         (mem_size),
        .mem_sign         (mem_sign),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'((i * 7 + 3) & 255);
        end else if (mem_write_enable) begin
            for (int i = 0; i < 4; i++)
                if (i < (1 << mem_size))
                    ram[(int'(mem_byte_address) + i) % 1024] <= mem_write_data[8*i +: 8];
        end
    end

    always_comb begin
        int a;
        logic [31:0] w;
        a = int'(mem_byte_address);
        w = {ram[(a+3)%1024], ram[(a+2)%1024], ram[(a+1)%1024], ram[a]};
        case (mem_size)
            2'b00:   mem_read_data = mem_sign ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
            2'b01:   mem_read_data = mem_sign ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
            default: mem_read_data = w;
        endcase
    end

    // Reference: arithmetic over the byte model.
    function automatic bit exp_err(input int a, input int s);
        return (s == 3) || (a + (1 << s) > 1024);
    endfunction

    function automatic logic [31:0] exp_read(input int a, input int s, input bit g);
        int n;
        longint v;
        n = 1 << s;
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) % 1024]) << (8 * i);
        if (g && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic model_write(input int a, input int s, input logic [31:0] d);
        for (int i = 0; i < (1 << s); i++) ref_mem[(a + i) % 1024] = 8'(d >> (8 * i));
    endtask

    function automatic logic rdy(input bit p);
        return p ? dbg_if.ready : cpu_if.ready;
    endfunction
    function automatic logic rv(input bit p);
        return p ? dbg_if.resp_valid : cpu_if.resp_valid;
    endfunction

    task automatic drive(input bit p, input logic v, input logic [9:0] a, input logic w,
                         input logic [31:0] d, input logic [1:0] s, input logic g);
        if (p) begin
            dbg_if.valid = v; dbg_if.addr = a; dbg_if.we = w;
            dbg_if.wdata = d; dbg_if.size = s; dbg_if.sign = g;
        end else begin
            cpu_if.valid = v; cpu_if.addr = a; cpu_if.we = w;
            cpu_if.wdata = d; cpu_if.size = s; cpu_if.sign = g;
        end
    endtask

    // Drives one request and records what the DUT does in cycles T..T+3.
    task automatic run_req(input bit p, input logic [9:0] a, input logic w,
                           input logic [31:0] d, input logic [1:0] s, input logic g,
                           output bit acc, output int we_t1, output int we_oth,
                           output bit rv_ok, output bit rv_bad,
                           output logic [31:0] rd, output logic er);
        acc = 0; we_t1 = 0; we_oth = 0; rv_ok = 0; rv_bad = 0; rd = '0; er = 1'b0;
        @(negedge clk);
        drive(p, 1'b1, a, w, d, s, g);
        for (int c = 0; c < 8; c++) begin
            #1;
            if (rdy(p)) begin acc = 1; break; end
            @(negedge clk);
        end
        if (!acc) begin drive(p, 1'b0, a, w, d, s, g); return; end
        we_oth += int'(mem_write_enable);
        if (rv(0) | rv(1)) rv_bad = 1;
        @(negedge clk);
        drive(p, 1'b0, a, w, d, s, g);
        #1;
        we_t1 = int'(mem_write_enable);
        if (rv(0) | rv(1) | rdy(0) | rdy(1)) rv_bad = 1;
        @(negedge clk);
        #1;
        we_oth += int'(mem_write_enable);
        rv_ok = rv(p);
        if (rv(!p) | rdy(0) | rdy(1)) rv_bad = 1;
        rd = p ? dbg_if.resp_rdata : cpu_if.resp_rdata;
        er = p ? dbg_if.resp_error : cpu_if.resp_error;
        @(negedge clk);
        #1;
        we_oth += int'(mem_write_enable);
        if (rv(0) | rv(1) | cpu_if.resp_error | dbg_if.resp_error
            | (|cpu_if.resp_rdata) | (|dbg_if.resp_rdata)) rv_bad = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; fill = 1'b1;
        drive(0, 1'b1, 10'h3, 1'b1, 32'h1, 2'b10, 1'b0);
        drive(1, 1'b1, 10'h7, 1'b0, 32'h2, 2'b00, 1'b1);
        @(negedge clk);
        fill = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({cpu_if.ready, dbg_if.ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got=%b exp=00", {cpu_if.ready, dbg_if.ready});
        end
        checks++;
        if ({rv(0), rv(1), cpu_if.resp_error, dbg_if.resp_error, mem_write_enable} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got=%b exp=00000",
                {rv(0), rv(1), cpu_if.resp_error, dbg_if.resp_error, mem_write_enable});
        end
        checks++;
        if ({cpu_if.resp_rdata, dbg_if.resp_rdata, mem_write_data, mem_byte_address,
             mem_size, mem_sign} !== '0) begin
            errors++; $display("FAIL reset_data got addr=%h wdata=%h rd=%h/%h exp=0",
                mem_byte_address, mem_write_data, cpu_if.resp_rdata, dbg_if.resp_rdata);
        end
        drive(0, 1'b0, 10'h0, 1'b0, 32'h0, 2'b00, 1'b0);
        drive(1, 1'b0, 10'h0, 1'b0, 32'h0, 2'b00, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        bit acc, rvok, rvbad; int wt1, wo; logic [31:0] rd; logic er;
        run_req(0, 10'h010, 1'b1, 32'hDEADBEEF, 2'b10, 1'b0, acc, wt1, wo, rvok, rvbad, rd, er);
        model_write(16, 2, 32'hDEADBEEF);
        checks++;
        if (!acc || wt1 !== 1 || wo !== 0) begin
            errors++; $display("FAIL wr_timing got acc=%0d we_t1=%0d we_other=%0d exp 1 1 0", acc, wt1, wo);
        end
        checks++;
        if (!rvok || rvbad || er !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL wr_resp got rv=%0d bad=%0d err=%b rd=%h exp rv=1 err=0 rd=0", rvok, rvbad, er, rd);
        end
        run_req(0, 10'h010, 1'b0, 32'h0, 2'b10, 1'b0, acc, wt1, wo, rvok, rvbad, rd, er);
        checks++;
        if (!acc || !rvok || rvbad || wt1 !== 0 || wo !== 0) begin
            errors++; $display("FAIL rd_timing got acc=%0d rv=%0d bad=%0d we=%0d/%0d", acc, rvok, rvbad, wt1, wo);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_data got=%h exp=deadbeef", rd);
        end
    endtask

    task automatic test_rr();
        int gq[$]; int gc[$]; int rq[$]; int bothr, rvboth, rdbad;
        logic [31:0] ea, eb;
        bothr = 0; rvboth = 0; rdbad = 0;
        ea = exp_read(10'h100, 2, 1'b0);
        eb = exp_read(10'h200, 2, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        drive(0, 1'b1, 10'h100, 1'b0, 32'h0, 2'b10, 1'b0);
        drive(1, 1'b1, 10'h200, 1'b0, 32'h0, 2'b10, 1'b0);
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (gq.size() >= 3) begin
                drive(0, 1'b0, 10'h100, 1'b0, 32'h0, 2'b10, 1'b0);
                drive(1, 1'b0, 10'h200, 1'b0, 32'h0, 2'b10, 1'b0);
            end
            #1;
            if (cpu_if.ready && dbg_if.ready) bothr++;
            if (cpu_if.ready) begin gq.push_back(0); gc.push_back(cyc); end
            if (dbg_if.ready) begin gq.push_back(1); gc.push_back(cyc); end
            if (rv(0) && rv(1)) rvboth++;
            if (rv(0)) begin rq.push_back(0); if (cpu_if.resp_rdata !== ea) rdbad++; end
            if (rv(1)) begin rq.push_back(1); if (dbg_if.resp_rdata !== eb) rdbad++; end
            @(negedge clk);
        end
        checks++;
        if (gq.size() != 3 || gq[0] != 0 || gq[1] != 1 || gq[2] != 0 || bothr != 0) begin
            errors++; $display("FAIL rr_grants got n=%0d seq=%p both=%0d exp 0,1,0", gq.size(), gq, bothr);
        end
        checks++;
        if (gc.size() != 3 || gc[0] != 0 || gc[1] != 3 || gc[2] != 6) begin
            errors++; $display("FAIL rr_spacing got=%p exp 0,3,6", gc);
        end
        checks++;
        if (rq.size() != 3 || rq[0] != 0 || rq[1] != 1 || rq[2] != 0 || rvboth != 0) begin
            errors++; $display("FAIL rr_resp_port got=%p both=%0d exp 0,1,0", rq, rvboth);
        end
        checks++;
        if (rdbad != 0) begin
            errors++; $display("FAIL rr_rdata got bad=%0d exp=0", rdbad);
        end
    endtask

    task automatic test_error();
        bit acc, rvok, rvbad; int wt1, wo; logic [31:0] rd; logic er;
        logic [9:0] ba [5]; logic [1:0] bs [5]; bit be [5];
        run_req(1, 10'h3FE, 1'b1, 32'hCAFEF00D, 2'b10, 1'b0, acc, wt1, wo, rvok, rvbad, rd, er);
        checks++;
        if (!acc || !rvok || rvbad || er !== 1'b1 || rd !== 32'h0 || wt1 !== 0 || wo !== 0) begin
            errors++; $display("FAIL err_top got acc=%0d rv=%0d err=%b rd=%h we=%0d exp err=1 rd=0 we=0", acc, rvok, er, rd, wt1);
        end
        checks++;
        if (ram[1022] !== ref_mem[1022] || ram[1023] !== ref_mem[1023] || ram[0] !== ref_mem[0]) begin
            errors++; $display("FAIL err_mem got=%h%h exp=%h%h", ram[1023], ram[1022], ref_mem[1023], ref_mem[1022]);
        end
        run_req(0, 10'h000, 1'b0, 32'h0, 2'b11, 1'b0, acc, wt1, wo, rvok, rvbad, rd, er);
        checks++;
        if (!acc || !rvok || rvbad || er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL err_size got rv=%0d err=%b rd=%h exp err=1 rd=0", rvok, er, rd);
        end
        ba = '{10'h3FC, 10'h3FD, 10'h3FF, 10'h3FE, 10'h3FF};
        bs = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
        foreach (ba[i]) begin
            be[i] = exp_err(int'(ba[i]), int'(bs[i]));
            run_req(1, ba[i], 1'b0, 32'h0, bs[i], 1'b0, acc, wt1, wo, rvok, rvbad, rd, er);
            checks++;
            if (!rvok || er !== be[i] || rd !== (be[i] ? 32'h0 : exp_read(int'(ba[i]), int'(bs[i]), 1'b0))) begin
                errors++; $display("FAIL edge_%0d got err=%b rd=%h exp err=%b", i, er, rd, be[i]);
            end
        end
    endtask

    task automatic test_half_sign();
        bit acc, rvok, rvbad; int wt1, wo; logic [31:0] rd; logic er;
        run_req(0, 10'h005, 1'b1, 32'h1234A5F0, 2'b01, 1'b0, acc, wt1, wo, rvok, rvbad, rd, er);
        model_write(5, 1, 32'h1234A5F0);
        checks++;
        if (wt1 !== 1 || er !== 1'b0) begin
            errors++; $display("FAIL half_wr got we=%0d err=%b exp we=1 err=0", wt1, er);
        end
        run_req(1, 10'h005, 1'b0, 32'h0, 2'b01, 1'b1, acc, wt1, wo, rvok, rvbad, rd, er);
        checks++;
        if (!rvok || rd !== 32'hFFFFA5F0) begin
            errors++; $display("FAIL half_signed got=%h exp=ffffa5f0", rd);
        end
        run_req(0, 10'h005, 1'b0, 32'h0, 2'b01, 1'b0, acc, wt1, wo, rvok, rvbad, rd, er);
        checks++;
        if (!rvok || rd !== 32'h0000A5F0) begin
            errors++; $display("FAIL half_unsigned got=%h exp=0000a5f0", rd);
        end
    endtask

    task automatic test_reset_access();
        bit acc, rvok, rvbad; int wt1, wo; logic [31:0] rd; logic er; int seen;
        seen = 0;
        @(negedge clk);
        drive(0, 1'b1, 10'h020, 1'b1, 32'h12345678, 2'b10, 1'b0);
        #1;
        checks++;
        if (cpu_if.ready !== 1'b1) begin
            errors++; $display("FAIL rst_acc_accept got=%b exp=1", cpu_if.ready);
        end
        @(negedge clk);
        drive(0, 1'b0, 10'h020, 1'b1, 32'h12345678, 2'b10, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL rst_acc_we got=%b exp=0", mem_write_enable);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (mem_byte_address !== 10'h0 || mem_write_data !== 32'h0) begin
            errors++; $display("FAIL rst_acc_memout got addr=%h wdata=%h exp=0", mem_byte_address, mem_write_data);
        end
        for (int c = 0; c < 3; c++) begin
            if (rv(0) | rv(1) | mem_write_enable) seen++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rst_acc_drop got=%0d exp=0", seen);
        end
        run_req(0, 10'h020, 1'b0, 32'h0, 2'b10, 1'b0, acc, wt1, wo, rvok, rvbad, rd, er);
        checks++;
        if (!rvok || rd !== exp_read(32, 2, 1'b0)) begin
            errors++; $display("FAIL rst_acc_prior got=%h exp=%h", rd, exp_read(32, 2, 1'b0));
        end
    endtask

    task automatic test_random();
        bit acc, rvok, rvbad; int wt1, wo; logic [31:0] rd; logic er;
        bit p, w, g, ee; logic [9:0] a; logic [1:0] s; logic [31:0] d, erd; int bad;
        for (int n = 0; n < 40; n++) begin
            p = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1020, 1023))
                                            : 10'($urandom_range(0, 1023));
            s = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            g = 1'($urandom_range(0, 1));
            d = $urandom;
            ee = exp_err(int'(a), int'(s));
            erd = (ee || w) ? 32'h0 : exp_read(int'(a), int'(s), g);
            run_req(p, a, w, d, s, g, acc, wt1, wo, rvok, rvbad, rd, er);
            if (w && !ee) model_write(int'(a), int'(s), d);
            checks++;
            if (!acc || !rvok || rvbad || wo !== 0 || wt1 !== int'(w && !ee)) begin
                errors++; $display("FAIL rand%0d_hs got acc=%0d rv=%0d bad=%0d we=%0d/%0d exp we=%0d",
                    n, acc, rvok, rvbad, wt1, wo, int'(w && !ee));
            end
            checks++;
            if (er !== ee || rd !== erd) begin
                errors++; $display("FAIL rand%0d_resp p=%0d a=%h s=%0d got err=%b rd=%h exp err=%b rd=%h",
                    n, p, a, s, er, rd, ee, erd);
            end
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mem_image got=%0d differing bytes exp=0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'((i * 7 + 3) & 255);
        test_reset();
        test_write_read();
        test_rr();
        test_error();
        test_half_sign();
        test_reset_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
